decoder16_scan_seq: RTL and testbench
=====================================

// Module: decoder16_scan_seq
// PURPOSE
// - Upstream sequencer for decoder16: generates the 4-bit select index d that the decoder expands to one-hot.
// - Steps a registered index from FIRST to LAST, holding each value DWELL+1 clocks.
// - Supports one-shot and continuous-loop modes, with abort via stop.
// - Drives decoder16.d directly; sel_valid gates downstream use of decoder16.out.
// PARAMETERS
// - N        4   select width; decoder output width is 2**N
// - DWELL_W  8   width of the dwell counter and dwell input
// PORTS
// - clk        in   1        single clock; all state updates on rising edge
// - rst_n      in   1        asynchronous, active-low reset
// - start      in   1        begin scan; sampled only in IDLE
// - stop       in   1        abort scan; returns to IDLE, no done pulse
// - mode_loop  in   1        1 = restart at first after last; 0 = one-shot
// - first      in   N        first index of scan; captured at start
// - last       in   N        last index of scan; captured at start
// - dwell      in   DWELL_W  extra hold cycles per index; captured at start
// - sel        out  N        current index; connects to decoder16.d
// - sel_valid  out  1        high while sel is an active scan index
// - step       out  1        1-cycle pulse in each cycle sel takes a new value
// - busy       out  1        high in RUN
// - done       out  1        1-cycle pulse when a one-shot scan completes
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; sel, sel_valid, step, busy, done, dwell counter and captured config all 0.
// - Reset asserted mid-scan clears everything immediately; no done pulse.
// - States: IDLE, RUN, FIN. Encoding is binary, defined in the shared defs.
// - IDLE, start=1 and stop=0 at edge k: capture first/last/dwell/mode_loop.
//   After edge k: sel=first, sel_valid=1, busy=1, step=1, cnt=0, state=RUN.
// - RUN: cnt increments each cycle. When cnt==dwell_q, the next edge advances the index and clears cnt.
//   Each index is held dwell_q+1 cycles; dwell=0 gives one index per cycle.
// - Index advance when sel!=last_q: sel <= sel+1 modulo 2**N (15 wraps to 0). first>last scans through the wrap.
// - Index advance when sel==last_q:
//   - mode_loop_q=1: sel <= first_q, step=1, stay in RUN.
//   - mode_loop_q=0: go to FIN; sel holds last_q, sel_valid=0, busy=0, done=1 for one cycle.
// - FIN lasts one cycle, then IDLE. done deasserts on the cycle after FIN.
// - first==last: a one-shot scan outputs the single index for dwell+1 cycles, then done.
// - stop=1 in RUN: next edge goes to IDLE; sel_valid, busy and step go to 0; sel holds its value; no done.
// - stop has priority over start and over an index advance in the same cycle.
// - start in RUN or FIN is ignored. Input changes during RUN have no effect (config is captured at start).
// - step is 0 in every cycle except those where sel was newly loaded or advanced.
// - All outputs are registered; no combinational path from input to output.
// STRUCTURE
// - Shared defs (scan_defs.vh): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2, and default widths.
// - Sub-module scan_dwell_cnt: DWELL_W counter with clear, enable and terminal-count (cnt==limit) output.
// - Top holds the FSM, config capture registers and the sel/flag output registers.
// - Bench instantiates decoder16_scan_seq feeding decoder16 and checks out == (1<<sel) whenever sel_valid=1.
// TESTING
// - first=0, last=3, dwell=0, loop=0, start pulse -> sel 0,1,2,3 on consecutive cycles with step=1 each cycle;
//   done=1 the cycle after sel=3 ends; sel_valid=0, sel stays 3.
// - first=2, last=3, dwell=2 -> sel=2 for 3 cycles, then 3 for 3 cycles; step pulses every 3rd cycle; out=0x0004 then 0x0008.
// - first=14, last=1, dwell=0, loop=0 -> sel 14,15,0,1 then done; out 0x4000,0x8000,0x0001,0x0002.
// - loop=1, first=5, last=6 -> 5,6,5,6,...; stop asserted -> next cycle busy=0, sel_valid=0, done never pulses.
// - start and stop together in IDLE -> stays IDLE. start pulse during RUN -> no restart; sequence unchanged.
// - rst_n dropped asynchronously mid-scan (sel=9) -> all outputs 0 before the next clk edge.
//   After release and a new start, the scan restarts from first.

Source files
------------

// File: rtl/decoder16_scan_seq_pkg.sv
// Shared definitions for the decoder16 scan sequencer: state encoding and
// default widths used by the sequencer top and its dwell counter.
package decoder16_scan_seq_pkg;

    // Default select width; the downstream decoder has 2**N outputs.
    localparam int N_DEF       = 4;

    // Default width of the dwell counter and of the dwell input.
    localparam int DWELL_W_DEF = 8;

    // Sequencer states, binary encoded.
    //   ST_IDLE : waiting for start, outputs quiet (sel holds last value)
    //   ST_RUN  : stepping sel from first to last
    //   ST_FIN  : one-cycle completion state that carries the done pulse
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage : decoder16_scan_seq_pkg

// File: rtl/decoder16.sv
// 4-to-16 one-hot decoder driven by the scan sequencer's sel output.
module decoder16 (
    input  logic [3:0]  d,
    output logic [15:0] out
);

    // One-hot expansion of the select index.
    always_comb begin
        out = 16'd1 << d;
    end

endmodule : decoder16

// File: rtl/scan_dwell_cnt.sv
// Dwell counter for the scan sequencer. Counts up while enabled, returns to
// zero on clear, and flags terminal count when the count equals the limit.
module scan_dwell_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count register: clear wins over enable; the sequencer clears on every
    // index change, so the count never runs past the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Terminal count: the current index has been held for limit+1 cycles
    // once this is seen in the cycle the index was loaded plus limit more.
    always_comb begin
        o_tc = (r_cnt == i_limit);
    end

endmodule : scan_dwell_cnt

// File: rtl/decoder16_scan_seq.sv
// Scan sequencer feeding decoder16: steps a registered index from first to
// last, holding each value dwell+1 clocks, in one-shot or looping mode.
//
// Output qualifier: sel_valid is a pure valid with no ready. While sel_valid
// is high, sel (and the decoder output it drives) names the active index;
// while it is low, sel may hold a stale value and must be ignored. step marks
// each cycle in which sel has just taken a new value, and done marks the one
// cycle after a one-shot scan finishes. All outputs come straight from flops.
import decoder16_scan_seq_pkg::*;

module decoder16_scan_seq #(
    parameter int N       = N_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_loop,
    input  logic [N-1:0]       first,
    input  logic [N-1:0]       last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N-1:0]       sel,
    output logic               sel_valid,
    output logic               step,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state
);

    // State and output registers.
    state_t             r_state;
    logic [N-1:0]       r_sel;
    logic               r_sel_valid;
    logic               r_step;
    logic               r_busy;
    logic               r_done;

    // Configuration captured when a scan starts; inputs are ignored after.
    logic [N-1:0]       r_first_q;
    logic [N-1:0]       r_last_q;
    logic [DWELL_W-1:0] r_dwell_q;
    logic               r_loop_q;

    // Next-state and control terms from the FSM decode.
    state_t             w_state_nxt;
    logic [N-1:0]       w_sel_nxt;
    logic               w_sel_valid_nxt;
    logic               w_step_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_capture;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_tc;
    logic [N-1:0]       w_sel_inc;

    // Dwell timing for the index currently on sel.
    scan_dwell_cnt #(
        .W (DWELL_W)
    ) u_dwell_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (r_dwell_q),
        .o_tc    (w_tc)
    );

    // Next index with natural modulo-2**N wrap, so first>last scans through 0.
    always_comb begin
        w_sel_inc = r_sel + {{(N-1){1'b0}}, 1'b1};
    end

    // FSM next-state and next-output decode. stop outranks both start and
    // an index advance; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_sel_valid_nxt = r_sel_valid;
        w_step_nxt      = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_capture       = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (start && !stop) begin
                    w_capture       = 1'b1;
                    w_state_nxt     = ST_RUN;
                    w_sel_nxt       = first;
                    w_sel_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_step_nxt      = 1'b1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort: sel keeps its value, no done pulse.
                    w_state_nxt     = ST_IDLE;
                    w_sel_valid_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                    w_cnt_clr       = 1'b1;
                end else if (w_tc) begin
                    w_cnt_clr = 1'b1;
                    if (r_sel != r_last_q) begin
                        w_sel_nxt  = w_sel_inc;
                        w_step_nxt = 1'b1;
                    end else if (r_loop_q) begin
                        w_sel_nxt  = r_first_q;
                        w_step_nxt = 1'b1;
                    end else begin
                        // One-shot complete: sel holds last, done for one cycle.
                        w_state_nxt     = ST_FIN;
                        w_sel_valid_nxt = 1'b0;
                        w_busy_nxt      = 1'b0;
                        w_done_nxt      = 1'b1;
                    end
                end else begin
                    w_cnt_en = 1'b1;
                end
            end

            ST_FIN: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_cnt_clr       = 1'b1;
                w_state_nxt     = ST_IDLE;
                w_sel_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_step      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_sel_valid <= w_sel_valid_nxt;
            r_step      <= w_step_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Configuration capture on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_q <= '0;
            r_last_q  <= '0;
            r_dwell_q <= '0;
            r_loop_q  <= 1'b0;
        end else if (w_capture) begin
            r_first_q <= first;
            r_last_q  <= last;
            r_dwell_q <= dwell;
            r_loop_q  <= mode_loop;
        end
    end

    // Registered outputs straight to the ports.
    always_comb begin
        sel       = r_sel;
        sel_valid = r_sel_valid;
        step      = r_step;
        busy      = r_busy;
        done      = r_done;
        dbg_state = r_state;
    end

endmodule : decoder16_scan_seq

// File: tb/tb_decoder16_scan_seq.sv
// Bench for decoder16_scan_seq driving decoder16. Expected outputs come from a
// scan model that lists the index sequence directly from first/last/dwell.
module tb_decoder16_scan_seq;
    import decoder16_scan_seq_pkg::*;

    // Clock / reset and DUT signals
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        mode_loop = 1'b0;
    logic [3:0]  first     = 4'd0;
    logic [3:0]  last      = 4'd0;
    logic [7:0]  dwell     = 8'd0;
    logic [3:0]  sel;
    logic        sel_valid;
    logic        step;
    logic        busy;
    logic        done;
    state_t      dbg_state;
    logic [15:0] dec_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected per-cycle outputs: {sel[3:0], sel_valid, step, busy, done}
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    decoder16_scan_seq #(.N(4), .DWELL_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_loop (mode_loop),
        .first     (first),
        .last      (last),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    decoder16 u_dec (
        .d   (sel),
        .out (dec_out)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, expected finish before 400000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] pack(input logic [3:0] s, input logic v,
                                        input logic st, input logic b, input logic d);
        return {s, v, st, b, d};
    endfunction

    // Model: each index in scan order appears dwell+1 cycles, step on its first.
    task automatic build_run(input logic [3:0] f, input logic [3:0] l,
                             input logic [7:0] dw, input logic lp, input int cap);
        int idx;
        bit fin;
        idx = int'(f);
        fin = 1'b0;
        exp_q.delete();
        while (!fin) begin
            for (int r = 0; r <= int'(dw); r++)
                exp_q.push_back(pack(4'(idx), 1'b1, (r == 0), 1'b1, 1'b0));
            if (lp) fin = (exp_q.size() >= cap);
            else    fin = (idx == int'(l));
            if (idx == int'(l)) idx = int'(f);
            else                idx = (idx + 1) % 16;
        end
    endtask

    task automatic check(input string tag, input int idx, input logic [7:0] e);
        logic [7:0] obs;
        logic [15:0] exp_oh;
        obs = {sel, sel_valid, step, busy, done};
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed sel/valid/step/busy/done=%h expected %h",
                   tag, idx, obs, e);
        end
        if (e[3]) begin
            exp_oh = 16'd1 << e[7:4];
            n_assert++;
            assert (dec_out === exp_oh) else begin
                n_fail++;
                $error("FAIL %s_dec[%0d]: observed out=%h expected %h", tag, idx, dec_out, exp_oh);
            end
        end
    endtask

    // Driver: start a scan, optionally assert stop, optionally scramble inputs.
    // Entered and left at posedge+1.
    task automatic scan(input logic [3:0] f, input logic [3:0] l, input logic [7:0] dw,
                        input logic lp, input int stop_at_in, input bit scramble,
                        input string tag);
        int stop_at;
        int run_cnt;
        logic [7:0] tail;
        stop_at = stop_at_in;
        build_run(f, l, dw, lp, (stop_at > 0) ? stop_at : 1);
        if (stop_at > exp_q.size()) stop_at = 0;
        if (stop_at > 0) begin
            while (exp_q.size() > stop_at) void'(exp_q.pop_back());
            tail = exp_q[exp_q.size()-1];
            run_cnt = stop_at;
            exp_q.push_back(pack(tail[7:4], 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(pack(tail[7:4], 1'b0, 1'b0, 1'b0, 1'b0));
        end else begin
            run_cnt = exp_q.size();
            exp_q.push_back(pack(l, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(pack(l, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(pack(l, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        first = f; last = l; dwell = dw; mode_loop = lp;
        start = 1'b1; stop = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(posedge clk); #1;
            check(tag, j, exp_q[j]);
            if (stop_at > 0 && j == stop_at - 1) begin
                stop  = 1'b1;
                start = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if ((stop_at > 0 && j < stop_at - 1) || (stop_at == 0 && j <= run_cnt)) begin
                stop = 1'b0;
                if (scramble) begin
                    start     = 1'($urandom_range(0, 1));
                    first     = 4'($urandom_range(0, 15));
                    last      = 4'($urandom_range(0, 15));
                    dwell     = 8'($urandom_range(0, 255));
                    mode_loop = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = 1'b0;
                stop  = 1'b0;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        logic [3:0] rf, rl;
        logic [7:0] rdw;
        logic       rlp;
        int         rsa;

        // Reset state, sampled while reset is held.
        #12;
        check("reset", 0, 8'h00);
        n_assert++;
        assert (dbg_state === ST_IDLE) else begin
            n_fail++;
            $error("FAIL reset_state: observed %0d expected %0d", dbg_state, ST_IDLE);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scans
        scan(4'd0,  4'd3, 8'd0, 1'b0, 0, 1'b0, "oneshot_0_3");
        scan(4'd2,  4'd3, 8'd2, 1'b0, 0, 1'b0, "dwell2_2_3");
        scan(4'd14, 4'd1, 8'd0, 1'b0, 0, 1'b0, "wrap_14_1");
        scan(4'd5,  4'd6, 8'd0, 1'b1, 9, 1'b0, "loop_stop_5_6");
        scan(4'd7,  4'd7, 8'd2, 1'b0, 0, 1'b0, "single_7");
        scan(4'd9,  4'd11, 8'd1, 1'b0, 6, 1'b0, "stop_at_last");

        // start and stop together in IDLE: no scan; sel holds 11 from the prior abort.
        first = 4'd4; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        check("start_stop_idle", 0, pack(4'd11, 1'b0, 1'b0, 1'b0, 1'b0));
        start = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
        check("start_stop_idle", 1, pack(4'd11, 1'b0, 1'b0, 1'b0, 1'b0));

        // Inputs (including start) churn during RUN without effect.
        scan(4'd3, 4'd8, 8'd1, 1'b0, 0, 1'b1, "run_churn");

        // Asynchronous reset mid-scan while sel=9.
        build_run(4'd7, 4'd12, 8'd1, 1'b0, 1);
        first = 4'd7; last = 4'd12; dwell = 8'd1; mode_loop = 1'b0; start = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            check("pre_rst", j, exp_q[j]);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, 8'h00);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 0, 8'h00);
        scan(4'd7, 4'd12, 8'd1, 1'b0, 0, 1'b0, "restart");

        // Randomized scans with input churn.
        repeat (25) begin
            rf  = 4'($urandom_range(0, 15));
            rl  = 4'($urandom_range(0, 15));
            rdw = 8'($urandom_range(0, 3));
            rlp = 1'($urandom_range(0, 1));
            if (rlp) rsa = $urandom_range(1, 30);
            else     rsa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
            scan(rf, rl, rdw, rlp, rsa, 1'b1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_decoder16_scan_seq
